// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory program loader
//
// Purpose:
//   Assembles big-endian 32-bit instruction words from single-cycle UART byte
//   strobes and writes them, one per cycle, into instruction memory starting
//   at byte address 0. A session ends in DONE once the halt word has been
//   written, or in ERROR once MEM_DEPTH words have been written without a
//   halt.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_reset       synchronous active-low reset
//   i_start       single-cycle pulse, begins a load session when not busy
//   i_rx_data     received byte, qualified by i_rx_done
//   i_rx_done     single-cycle byte strobe
//   o_wr_en       instruction memory write enable (one-cycle pulse)
//   o_wr_addr     byte address of the word being written (multiple of 4)
//   o_wr_data     assembled instruction word
//   o_busy        load session in progress
//   o_done        halt word written
//   o_error       memory capacity exceeded
//   o_word_count  words written in the current session, halt word included

module imem_loader #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 256,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_wr_en,
  output logic [31:0]           o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [15:0]           o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  localparam logic [15:0] DEPTH_CNT = 16'(MEM_DEPTH);

  state_e                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [31:0]             addr_q, addr_d;
  logic [15:0]             count_q, count_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [15:0]             next_count;
  logic [DATA_WIDTH-1:0]   shifted_word;

  assign next_count   = count_q + 16'd1;
  // New byte enters at the bottom; after four strobes the first byte sits in
  // the top lane, giving big-endian assembly.
  assign shifted_word = {shift_q[DATA_WIDTH-9:0], i_rx_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      // Idle and both terminal states share the session-start path; byte
      // strobes are ignored here.
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d    = S_RECV;
          byte_cnt_d = 2'd0;
          shift_d    = '0;
          addr_d     = 32'd0;
          count_d    = 16'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end

      S_RECV: begin
        if (i_rx_done) begin
          shift_d = shifted_word;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            wr_en_d    = 1'b1;
            wr_data_d  = shifted_word;
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        count_d = next_count;
        if (wr_data_q == HALT_WORD) begin
          // Halt wins even when it lands on the last memory location.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (next_count == DEPTH_CNT) begin
          state_d = S_ERROR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          state_d = S_RECV;
          addr_d  = addr_q + 32'd4;
          // A strobe arriving during the write cycle starts the next word.
          if (i_rx_done) begin
            shift_d    = {{(DATA_WIDTH-8){1'b0}}, i_rx_data};
            byte_cnt_d = 2'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      addr_q     <= 32'd0;
      count_q    <= 16'd0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_word_count = count_q;

endmodule
